ahb_wdt: RTL and testbench
==========================

// Module: ahb_wdt
// PURPOSE
//  AHB-Lite responder (slave) watchdog on the system AHB, answering transfers issued by the E902 BIU.
//  Drives the SoC watchdog_interrupt (first expiry) and watchdog_reset (second expiry) nets.
//  The reset request is fed into mcu_reset.
//  Zero-wait-state register access; ERROR response for illegal accesses.
// PARAMETERS
//  ADDR_W      8             offset bits of haddr decoded (upper bits ignored; decoder drives hsel)
//  RST_PULSE   16            wdt_rst_req high time in sys_clk cycles (>=1)
//  LOAD_INIT   32'hFFFF_FFFF reset value of LOAD
// PORTS
//  sys_clk      in   1   system clock
//  sys_resetn   in   1   async active-low reset
//  hsel         in   1   slave select from sysahb decoder
//  haddr        in   32  address (bits [ADDR_W-1:0] used)
//  htrans       in   2   transfer type; NONSEQ/SEQ = htrans[1]
//  hwrite       in   1   1=write
//  hsize        in   3   must be 3'b010 (word)
//  hwdata       in   32  write data (data phase)
//  hready       in   1   bus ready (qualifies address phase)
//  hreadyout    out  1   slave ready
//  hresp        out  1   0=OKAY 1=ERROR
//  hrdata       out  32  read data (data phase)
//  wdt_int      out  1   level interrupt = STATUS.INT & CTRL.INTEN
//  wdt_rst_req  out  1   reset request pulse
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=0, hrdata=0, wdt_int=0, wdt_rst_req=0.
//   CTRL=0, LOAD=LOAD_INIT, VALUE=LOAD_INIT, STATUS=0, unlocked, FSM=IDLE.
//  Registers (word offsets): 0x00 CTRL[0]=EN [1]=RSTEN [2]=INTEN | 0x04 LOAD RW | 0x08 VALUE RO.
//   0x0C KEY WO: 0x5A5A_A5A5 = kick, other values ignored | 0x10 STATUS[0]=INT, W1C.
//   0x14 LOCK: write 0x1ACC_E551 unlocks, any other value locks; read [0]=locked.
//  Locked: writes to CTRL/LOAD are dropped silently (OKAY). KEY/STATUS remain writable.
//  Address phase accepted when hsel & htrans[1] & hready. Addr/write/size registered; write applied in
//   the data phase using hwdata. Read hrdata valid in the data phase. Unused bits read 0.
//  ERROR when hsize!=word, offset unmapped, or write to VALUE: two-cycle response --
//   cycle1 hreadyout=0 hresp=1, cycle2 hreadyout=1 hresp=1; no register changes.
//   A transfer pending behind an ERROR is accepted normally.
//  Bus FSM: BUS_IDLE -> BUS_ERR1 -> BUS_ERR2 -> BUS_IDLE; OKAY transfers stay in BUS_IDLE.
//  Watchdog FSM: IDLE (EN=0, VALUE holds) -> COUNT on EN 0->1 (VALUE<=LOAD next cycle).
//   COUNT: VALUE-- per tick. At VALUE==0 & tick: STATUS.INT<=1, VALUE<=LOAD, go WARN.
//   WARN: counts again. At 0 & tick: if RSTEN, go RESET; else set INT again, reload, stay WARN.
//   RESET: wdt_rst_req=1 for RST_PULSE cycles, then VALUE<=LOAD, INT<=0, go COUNT.
//   Kick (KEY correct): VALUE<=LOAD next cycle; WARN->COUNT. INT is not cleared (W1C only).
//   EN 1->0 in any state -> IDLE. This aborts the RESET pulse (wdt_rst_req drops next cycle).
//  Simultaneous events:
//   - kick and expiry in the same cycle: kick wins, no expiry.
//   - W1C of INT and INT set in the same cycle: set wins.
//   - LOAD write while counting: used at next reload/kick only.
//   - LOAD=0: expiry on the first tick after each reload.
//  Arithmetic: 32-bit unsigned down-counter; never wraps below 0.
//  sys_resetn low mid-operation: everything returns to reset values asynchronously.
// CONFIGURATION
//  WDT_PRESCALER_EN defined: adds 0x18 PRESC[15:0], RW and lock-protected, reset 0.
//   tick = 1 cycle every PRESC+1 cycles. Prescaler count restarts on kick, reload or EN rise.
//  Undefined: tick every cycle while EN; offset 0x18 is unmapped (ERROR response).
// TESTING
//  1. Reset, then read 0x04/0x08/0x00 -> 0xFFFF_FFFF / 0xFFFF_FFFF / 0x0, all OKAY with hreadyout=1.
//  2. LOAD=10, CTRL=0x7; no kick -> wdt_int rises 11 cycles after EN data phase.
//     wdt_rst_req high 11 cycles later, for 16 cycles; VALUE reloads to 10.
//  3. LOAD=10, EN; KEY=0x5A5A_A5A5 every 8 cycles -> wdt_int and wdt_rst_req stay 0.
//     KEY=0x1234 -> no reload.
//  4. LOCK=0 (locked), write CTRL=0 -> CTRL reads 0x7.
//     LOCK=0x1ACC_E551, write CTRL=0 -> reads 0x0, VALUE frozen.
//  5. Byte read (hsize=0) of 0x00 and word write to 0x08 -> two-cycle ERROR each (hreadyout 0 then 1).
//     Registers unchanged; a back-to-back OKAY read completes.
//  6. WDT_PRESCALER_EN, PRESC=3, LOAD=2 -> first expiry at 12 cycles.
//     Without the macro, access to 0x18 returns ERROR.

Source files
------------

// File: rtl/ahb_wdt.sv
// AHB-Lite watchdog: zero-wait register file, interrupt on first expiry, reset pulse on second.
// Optional WDT_PRESCALER_EN adds the PRESC register (offset 0x18) and a tick prescaler.
module ahb_wdt #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RST_PULSE = 16,
  parameter logic [31:0] LOAD_INIT = 32'hFFFF_FFFF
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        wdt_int,
  output logic        wdt_rst_req
);

  localparam int unsigned RCNT_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [31:0] KICK_KEY   = 32'h5A5A_A5A5;
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;
  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_LOAD   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OFF_VALUE  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OFF_KEY    = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] OFF_LOCK   = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] OFF_PRESC  = ADDR_W'(8'h18);

  typedef enum logic [1:0] {BUS_IDLE, BUS_ERR1, BUS_ERR2} bus_state_t;
  typedef enum logic [1:0] {WD_IDLE, WD_COUNT, WD_WARN, WD_RESET} wd_state_t;

  bus_state_t        r_bus_st;
  wd_state_t         r_wd_st;
  logic              r_dp_wr;
  logic [ADDR_W-1:0] r_dp_off;
  logic [2:0]        r_ctrl;
  logic [31:0]       r_load;
  logic [31:0]       r_value;
  logic              r_int;
  logic              r_locked;
  logic [RCNT_W-1:0] r_rst_cnt;

  logic [ADDR_W-1:0] w_off;
  logic              w_accept, w_mapped, w_err;
  logic              w_wr_ctrl, w_wr_load, w_wr_lock, w_kick, w_w1c;
  logic [2:0]        w_ctrl_nxt;
  logic [31:0]       w_load_nxt;
  logic              w_locked_nxt;
  logic              w_en_rise, w_en_fall, w_active, w_tick, w_expire;
  logic              w_int_set, w_pulse_end, w_int_nxt;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused = ^{haddr[31:ADDR_W], htrans[0]};

  assign w_off    = haddr[ADDR_W-1:0];
  assign w_accept = hsel & htrans[1] & hready;
  assign w_err    = (hsize != 3'b010) | ~w_mapped | (hwrite & (w_off == OFF_VALUE));

  always_comb begin
    w_mapped = 1'b0;
    case (w_off)
      OFF_CTRL, OFF_LOAD, OFF_VALUE, OFF_KEY, OFF_STATUS, OFF_LOCK: w_mapped = 1'b1;
`ifdef WDT_PRESCALER_EN
      OFF_PRESC: w_mapped = 1'b1;
`endif
      default: w_mapped = 1'b0;
    endcase
  end

  // Data-phase write decode; lock gates only the configuration registers.
  assign w_wr_ctrl    = r_dp_wr & (r_dp_off == OFF_CTRL) & ~r_locked;
  assign w_wr_load    = r_dp_wr & (r_dp_off == OFF_LOAD) & ~r_locked;
  assign w_wr_lock    = r_dp_wr & (r_dp_off == OFF_LOCK);
  assign w_kick       = r_dp_wr & (r_dp_off == OFF_KEY) & (hwdata == KICK_KEY);
  assign w_w1c        = r_dp_wr & (r_dp_off == OFF_STATUS) & hwdata[0];
  assign w_ctrl_nxt   = w_wr_ctrl ? hwdata[2:0] : r_ctrl;
  assign w_load_nxt   = w_wr_load ? hwdata : r_load;
  assign w_locked_nxt = w_wr_lock ? (hwdata != UNLOCK_KEY) : r_locked;

  assign w_en_rise   = w_ctrl_nxt[0] & ~r_ctrl[0];
  assign w_en_fall   = r_ctrl[0] & ~w_ctrl_nxt[0];
  assign w_active    = (r_wd_st == WD_COUNT) | (r_wd_st == WD_WARN);
  assign w_expire    = w_active & ~w_en_fall & ~w_kick & w_tick & (r_value == '0);
  assign w_int_set   = w_expire & ((r_wd_st == WD_COUNT) | ~r_ctrl[1]);
  assign w_pulse_end = (r_wd_st == WD_RESET) & (r_rst_cnt == '0) & ~w_en_fall;
  assign w_int_nxt   = w_int_set | (r_int & ~w_w1c & ~w_pulse_end);

`ifdef WDT_PRESCALER_EN
  logic        w_wr_presc;
  logic [15:0] w_presc_nxt;
  logic [15:0] r_presc, r_pcnt;
  assign w_wr_presc  = r_dp_wr & (r_dp_off == OFF_PRESC) & ~r_locked;
  assign w_presc_nxt = w_wr_presc ? hwdata[15:0] : r_presc;
  // >= keeps the tick alive if PRESC is lowered below the running count.
  assign w_tick      = (r_pcnt >= r_presc);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_presc <= '0;
      r_pcnt  <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      if (w_tick | w_kick | w_en_rise | w_pulse_end) r_pcnt <= '0;
      else                                           r_pcnt <= r_pcnt + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // VALUE/STATUS read their state at the address phase; config registers forward the in-flight write.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata = 32'(w_ctrl_nxt);
      OFF_LOAD:   w_rdata = w_load_nxt;
      OFF_VALUE:  w_rdata = r_value;
      OFF_STATUS: w_rdata = 32'(r_int);
      OFF_LOCK:   w_rdata = 32'(w_locked_nxt);
`ifdef WDT_PRESCALER_EN
      OFF_PRESC:  w_rdata = 32'(w_presc_nxt);
`endif
      default:    w_rdata = '0;
    endcase
  end

  // Bus response FSM: OKAY in one cycle, ERROR as the two-cycle sequence.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_bus_st  <= BUS_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      r_dp_wr   <= 1'b0;
      r_dp_off  <= '0;
    end else begin
      r_dp_wr <= 1'b0;
      hrdata  <= '0;
      case (r_bus_st)
        BUS_ERR1: begin
          r_bus_st  <= BUS_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          if (w_accept & w_err) begin
            r_bus_st  <= BUS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
          end else begin
            r_bus_st  <= BUS_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            if (w_accept) begin
              r_dp_wr  <= hwrite;
              r_dp_off <= w_off;
              if (!hwrite) hrdata <= w_rdata;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_ctrl   <= '0;
      r_load   <= LOAD_INIT;
      r_locked <= 1'b0;
      r_int    <= 1'b0;
      wdt_int  <= 1'b0;
    end else begin
      r_ctrl   <= w_ctrl_nxt;
      r_load   <= w_load_nxt;
      r_locked <= w_locked_nxt;
      r_int    <= w_int_nxt;
      wdt_int  <= w_int_nxt & w_ctrl_nxt[2];
    end
  end

  // Watchdog FSM; disabling wins over everything, kick wins over expiry.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_wd_st     <= WD_IDLE;
      r_value     <= LOAD_INIT;
      r_rst_cnt   <= '0;
      wdt_rst_req <= 1'b0;
    end else if (w_en_fall) begin
      r_wd_st     <= WD_IDLE;
      wdt_rst_req <= 1'b0;
    end else if (w_en_rise) begin
      r_wd_st <= WD_COUNT;
      r_value <= r_load;
    end else begin
      case (r_wd_st)
        WD_COUNT, WD_WARN: begin
          if (w_kick) begin
            r_value <= r_load;
            r_wd_st <= WD_COUNT;
          end else if (w_tick) begin
            if (r_value != '0) begin
              r_value <= r_value - 32'd1;
            end else if (r_wd_st == WD_COUNT) begin
              r_value <= r_load;
              r_wd_st <= WD_WARN;
            end else if (r_ctrl[1]) begin
              r_wd_st     <= WD_RESET;
              wdt_rst_req <= 1'b1;
              r_rst_cnt   <= RCNT_W'(RST_PULSE - 1);
            end else begin
              r_value <= r_load;
            end
          end
        end
        WD_RESET: begin
          if (r_rst_cnt == '0) begin
            wdt_rst_req <= 1'b0;
            r_value     <= r_load;
            r_wd_st     <= WD_COUNT;
          end else begin
            r_rst_cnt <= r_rst_cnt - RCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_wdt.sv
// Randomised + directed bench for ahb_wdt with a behavioural model and a response scoreboard.
module tb_ahb_wdt;
  localparam int unsigned RST_PULSE = 16;
  localparam logic [31:0] KICK   = 32'h5A5A_A5A5;
  localparam logic [31:0] UNLOCK = 32'h1ACC_E551;

  logic        sys_clk = 1'b0;
  logic        sys_resetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout, hresp, wdt_int, wdt_rst_req;
  logic [31:0] hrdata;

  assign hready = hreadyout;

  ahb_wdt #(.ADDR_W(8), .RST_PULSE(RST_PULSE), .LOAD_INIT(32'hFFFF_FFFF)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .wdt_int(wdt_int), .wdt_rst_req(wdt_rst_req));

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {logic err; logic rd; logic [31:0] data;} exp_t;
  exp_t exp_q[$];

  localparam int M_IDLE = 0, M_COUNT = 1, M_WARN = 2, M_RESET = 3;
  bit          m_en, m_rsten, m_inten, m_int, m_locked, m_rst;
  logic [31:0] m_load, m_value;
  int          m_presc, m_pdiv, m_mode, m_pulse_left, m_bus;
  bit          m_dp_wr;
  logic [7:0]  m_dp_off;
  bit          m_int_out, m_rst_out;

  function automatic bit mapped(input logic [7:0] off);
    if (off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14}) return 1'b1;
`ifdef WDT_PRESCALER_EN
    if (off == 8'h18) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_en = 0; m_rsten = 0; m_inten = 0; m_int = 0; m_locked = 0; m_rst = 0;
    m_load = 32'hFFFF_FFFF; m_value = 32'hFFFF_FFFF;
    m_presc = 0; m_pdiv = 0; m_mode = M_IDLE; m_pulse_left = 0; m_bus = 0;
    m_dp_wr = 0; m_dp_off = '0; m_int_out = 0; m_rst_out = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] o_value = m_value;
    logic [31:0] o_load  = m_load;
    bit o_int = m_int, o_en = m_en, o_rsten = m_rsten;
    int o_presc = m_presc;
    bit kick = 0, acc, err, nxt_dp_wr = 0;
    logic [7:0] off;
    exp_t e;
    if (m_dp_wr) begin
      case (m_dp_off)
        8'h00: if (!m_locked) begin m_en = hwdata[0]; m_rsten = hwdata[1]; m_inten = hwdata[2]; end
        8'h04: if (!m_locked) m_load = hwdata;
        8'h0C: kick = (hwdata == KICK);
        8'h10: if (hwdata[0]) m_int = 0;
        8'h14: m_locked = (hwdata != UNLOCK);
`ifdef WDT_PRESCALER_EN
        8'h18: if (!m_locked) m_presc = int'(hwdata[15:0]);
`endif
        default: ;
      endcase
    end
    if (o_en && !m_en) begin
      m_mode = M_IDLE; m_rst = 0;
    end else if (!o_en && m_en) begin
      m_mode = M_COUNT; m_value = o_load; m_pdiv = 0;
    end else if (m_mode == M_COUNT || m_mode == M_WARN) begin
      if (kick) begin
        m_value = o_load; m_pdiv = 0; m_mode = M_COUNT;
      end else if (m_pdiv < o_presc) begin
        m_pdiv++;
      end else begin
        m_pdiv = 0;
        if (m_value > 0) m_value = m_value - 1;
        else if (m_mode == M_COUNT) begin m_int = 1; m_value = o_load; m_mode = M_WARN; end
        else if (o_rsten) begin m_mode = M_RESET; m_rst = 1; m_pulse_left = RST_PULSE; end
        else begin m_int = 1; m_value = o_load; end
      end
    end else if (m_mode == M_RESET) begin
      m_pulse_left--;
      if (m_pulse_left == 0) begin
        m_mode = M_COUNT; m_value = o_load; m_int = 0; m_rst = 0; m_pdiv = 0;
      end
    end
    // address phase
    if (m_bus == 1) begin
      m_bus = 2;
    end else begin
      m_bus = 0;
      acc = hsel && htrans[1];
      if (acc) begin
        off = haddr[7:0];
        err = (hsize != 3'b010) || !mapped(off) || (hwrite && off == 8'h08);
        e.err = err; e.rd = !hwrite && !err; e.data = '0;
        if (err) m_bus = 1;
        else begin
          nxt_dp_wr = hwrite; m_dp_off = off;
          case (off)
            8'h00: e.data = {29'b0, m_inten, m_rsten, m_en};
            8'h04: e.data = m_load;
            8'h08: e.data = o_value;
            8'h10: e.data = {31'b0, o_int};
            8'h14: e.data = {31'b0, m_locked};
            8'h18: e.data = m_presc;
            default: e.data = '0;
          endcase
        end
        exp_q.push_back(e);
      end
    end
    m_dp_wr = nxt_dp_wr;
    m_int_out = m_int && m_inten;
    m_rst_out = m_rst;
  endtask

  always @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  logic mon_dp;
  bit   saw_wait = 0;
  always @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) mon_dp <= 1'b0;
    else mon_dp <= (hsel & htrans[1] & hready) | (mon_dp & ~hreadyout);
  end

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_resetn) begin
      if (mon_dp) begin
        if (!hreadyout) begin
          saw_wait = 1;
          chk("err_first_cycle_hresp", hresp, 1'b1);
        end else if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd0, 32'd1);
          saw_wait = 0;
        end else begin
          e = exp_q.pop_front();
          chk("hresp", hresp, e.err);
          chk("wait_state", saw_wait, e.err);
          if (e.rd) chk("hrdata", hrdata, e.data);
          saw_wait = 0;
        end
      end
      chk("wdt_int", wdt_int, m_int_out);
      chk("wdt_rst_req", wdt_rst_req, m_rst_out);
    end
  end

  // ---------------- driver ----------------
  logic       op_wr[$];
  logic [7:0] op_off[$];
  logic [2:0] op_sz[$];
  logic [31:0] op_d[$];

  task automatic add(input logic wr, input logic [7:0] off, input logic [2:0] sz, input logic [31:0] d);
    op_wr.push_back(wr); op_off.push_back(off); op_sz.push_back(sz); op_d.push_back(d);
  endtask

  task automatic go();
    int n = op_wr.size();
    for (int i = 0; i <= n; i++) begin
      int w = 0;
      if (i < n) begin
        hsel = 1; htrans = 2'b10; haddr = {24'hA5_C300, op_off[i]};
        hwrite = op_wr[i]; hsize = op_sz[i];
      end else begin
        hsel = 0; htrans = 2'b00; hwrite = 0; hsize = 3'b010;
      end
      hwdata = (i > 0 && op_wr[i-1]) ? op_d[i-1] : $urandom;
      while (!hready && w < 50) begin @(negedge sys_clk); w++; end
      if (w >= 50) chk("hready_timeout", 32'd0, 32'd1);
      @(negedge sys_clk);
    end
    op_wr.delete(); op_off.delete(); op_sz.delete(); op_d.delete();
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d); add(1, off, 3'b010, d); endtask
  task automatic rd(input logic [7:0] off); add(0, off, 3'b010, 32'h0); endtask

  task automatic cycles_until(input bit which_rst, input int limit, output int k);
    k = 0;
    while ((which_rst ? wdt_rst_req : wdt_int) !== 1'b1 && k < limit) begin
      @(negedge sys_clk); k++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, hreadyout, 1'b1);
    chk({tag, "_hresp"}, hresp, 1'b0);
    chk({tag, "_hrdata"}, hrdata, 32'h0);
    chk({tag, "_wdt_int"}, wdt_int, 1'b0);
    chk({tag, "_wdt_rst_req"}, wdt_rst_req, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k, width;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_resetn = 1'b1;
    @(negedge sys_clk);

    // reset values
    rd(8'h04); rd(8'h08); rd(8'h00); go();

    // expiry timing: interrupt 11 cycles after EN, reset 11 later, RST_PULSE wide
    wr(8'h04, 32'd10); go();
    wr(8'h00, 32'h7); go();
    cycles_until(0, 100, k); chk("int_delay", k, 11);
    cycles_until(1, 100, k); chk("rst_delay", k, 11);
    width = 0;
    while (wdt_rst_req === 1'b1 && width < 100) begin @(negedge sys_clk); width++; end
    chk("rst_width", width, RST_PULSE);
    rd(8'h08); rd(8'h10); go();
    wr(8'h00, 32'h0); wr(8'h10, 32'h1); rd(8'h10); go();

    // regular kicks prevent expiry; wrong key does not reload
    wr(8'h00, 32'h7); go();
    for (int i = 0; i < 12; i++) begin
      wr(8'h0C, KICK); go();
      repeat (6) @(negedge sys_clk);
    end
    chk("kicked_int", wdt_int, 1'b0);
    chk("kicked_rst", wdt_rst_req, 1'b0);
    rd(8'h08); wr(8'h0C, 32'h1234); rd(8'h08); go();
    repeat (3) @(negedge sys_clk);
    rd(8'h08); go();

    // lock
    wr(8'h14, 32'h0); wr(8'h00, 32'h0); rd(8'h00); rd(8'h14); go();
    wr(8'h04, 32'd99); rd(8'h04); go();
    wr(8'h14, UNLOCK); wr(8'h00, 32'h0); rd(8'h00); rd(8'h08); go();
    repeat (5) @(negedge sys_clk);
    rd(8'h08); rd(8'h14); go();

    // errors with back-to-back OKAY transfers
    add(0, 8'h00, 3'b000, 0); rd(8'h04); go();
    wr(8'h08, 32'h55); rd(8'h08); go();
    rd(8'h1C); rd(8'h02); wr(8'h00, 32'h1); rd(8'h00); go();
    wr(8'h00, 32'h0); wr(8'h10, 32'h1); go();

    // offset 0x18: prescaler when present, otherwise an ERROR
    wr(8'h18, 32'h3); rd(8'h18); go();
`ifdef WDT_PRESCALER_EN
    wr(8'h04, 32'd2); wr(8'h00, 32'h5); go();
    cycles_until(0, 100, k); chk("presc_int_delay", k, 12);
    wr(8'h00, 32'h0); wr(8'h18, 32'h0); wr(8'h10, 32'h1); go();
`endif

    // randomized traffic
    for (int b = 0; b < 60; b++) begin
      int n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        logic [7:0] offs[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h06};
        logic [7:0] off = offs[$urandom_range(0, 8)];
        logic [2:0] sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'b010;
        logic [31:0] d = $urandom;
        case (off)
          8'h00: d = {29'b0, 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 3) != 0)};
          8'h04: d = $urandom_range(0, 30);
          8'h0C: d = ($urandom_range(0, 9) < 7) ? KICK : d;
          8'h14: d = ($urandom_range(0, 9) < 6) ? UNLOCK : d;
          8'h18: d = $urandom_range(0, 3);
          default: ;
        endcase
        add($urandom_range(0, 1), off, sz, d);
      end
      go();
      repeat ($urandom_range(0, 15)) @(negedge sys_clk);
      if (b == 40) begin
        #2 sys_resetn = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge sys_clk); @(negedge sys_clk);
        #2 sys_resetn = 1'b1;
        @(negedge sys_clk);
        rd(8'h04); rd(8'h08); rd(8'h00); rd(8'h14); go();
      end
    end

    repeat (4) @(negedge sys_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
